// File: rtl/tempo_selector_pkg.sv
// Shared definitions for the tempo selector: channel count, FSM states and the BPM table.
package tempo_selector_pkg;

    localparam int unsigned NUM_TEMPOS = 6;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPARE = 2'd1,
        PUBLISH = 2'd2
    } state_t;

    function automatic logic [7:0] bpm_of(input logic [IDX_W-1:0] idx);
        logic [7:0] bpm;
        unique case (idx)
            3'd0:    bpm = 8'd60;
            3'd1:    bpm = 8'd90;
            3'd2:    bpm = 8'd120;
            3'd3:    bpm = 8'd180;
            3'd4:    bpm = 8'd210;
            3'd5:    bpm = 8'd240;
            default: bpm = 8'd0;
        endcase
        return bpm;
    endfunction

endpackage

// File: rtl/energy_acc.sv
// Per-channel energy accumulator: sums |sample| with saturation and hands the
// window total to a snapshot register when the window closes.
module energy_acc #(
    parameter int unsigned ACC_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_en,
    input  logic              window_end,
    input  logic signed [7:0] sample,
    output logic [ACC_W-1:0]  snap
);

    logic [7:0]       mag;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] sat_sum;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] snap_q;

    // Two's complement negate keeps -128 as 8'h80, i.e. magnitude 128.
    always_comb begin
        mag     = sample[7] ? (~$unsigned(sample) + 8'd1) : $unsigned(sample);
        sum     = {1'b0, acc_q} + {{(ACC_W - 7){1'b0}}, mag};
        sat_sum = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else if (sample_en) begin
            if (window_end) begin
                snap_q <= sat_sum;
                acc_q  <= '0;
            end else begin
                acc_q  <= sat_sum;
            end
        end
    end

    assign snap = snap_q;

endmodule

// File: rtl/tempo_selector.sv
// Tempo selector: accumulates comb-filter energy per window, then scans the
// snapshot bank for the strongest channel and publishes its BPM.
module tempo_selector
    import tempo_selector_pkg::*;
#(
    parameter int unsigned WINDOW_LEN = 4096,
    parameter int unsigned ACC_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic signed [7:0] comb60,
    input  logic signed [7:0] comb90,
    input  logic signed [7:0] comb120,
    input  logic signed [7:0] comb180,
    input  logic signed [7:0] comb210,
    input  logic signed [7:0] comb240,
    output logic [7:0]        tempo_bpm,
    output logic [2:0]        tempo_idx,
    output logic              tempo_valid,
    output logic              no_beat,
    output logic              busy
);

    logic signed [7:0] comb [NUM_TEMPOS];
    logic [ACC_W-1:0]  snap [NUM_TEMPOS];

    assign comb[0] = comb60;
    assign comb[1] = comb90;
    assign comb[2] = comb120;
    assign comb[3] = comb180;
    assign comb[4] = comb210;
    assign comb[5] = comb240;

    logic [CNT_W-1:0] cnt_q;
    logic             window_end;

    assign window_end = ready && (cnt_q == CNT_W'(WINDOW_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (ready) begin
            cnt_q <= window_end ? '0 : cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_TEMPOS; i++) begin : g_ch
        energy_acc #(
            .ACC_W (ACC_W)
        ) u_acc (
            .clk        (clk),
            .reset      (reset),
            .sample_en  (ready),
            .window_end (window_end),
            .sample     (comb[i]),
            .snap       (snap[i])
        );
    end

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cmp_cnt_q;
    logic [ACC_W-1:0] max_q;
    logic [IDX_W-1:0] max_idx_q;
    logic [ACC_W-1:0] cur_snap;

    assign cur_snap = snap[cmp_cnt_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACCUM:   if (window_end) state_d = COMPARE;
            COMPARE: if (cmp_cnt_q == IDX_W'(NUM_TEMPOS - 1)) state_d = PUBLISH;
            PUBLISH: state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Strictly-greater update so ties keep the lowest channel index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_cnt_q <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
        end else if (state_q == ACCUM && window_end) begin
            cmp_cnt_q <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
        end else if (state_q == COMPARE) begin
            cmp_cnt_q <= cmp_cnt_q + 1'b1;
            if (cur_snap > max_q) begin
                max_q     <= cur_snap;
                max_idx_q <= cmp_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tempo_bpm   <= '0;
            tempo_idx   <= '0;
            tempo_valid <= 1'b0;
            no_beat     <= 1'b1;
        end else begin
            tempo_valid <= 1'b0;
            if (state_q == PUBLISH) begin
                tempo_valid <= 1'b1;
                if (max_q == '0) begin
                    no_beat <= 1'b1;
                end else begin
                    no_beat   <= 1'b0;
                    tempo_idx <= max_idx_q;
                    tempo_bpm <= bpm_of(max_idx_q);
                end
            end
        end
    end

    assign busy = (state_q != ACCUM);

endmodule

// File: tb/tb_tempo_selector.sv
// Bench for tempo_selector: directed scenarios plus random traffic checked
// against a window-level energy/argmax model.
module tb_tempo_selector;

    localparam int unsigned WL   = 8;
    localparam longint      MAXV = (64'd1 << 24) - 1;

    logic clk = 1'b0;
    logic reset;
    logic ready;
    logic signed [7:0] c0, c1, c2, c3, c4, c5;
    logic [7:0] tempo_bpm;
    logic [2:0] tempo_idx;
    logic tempo_valid, no_beat, busy;

    logic ready_s;
    logic signed [7:0] s0, s3;
    logic [7:0] bpm_s;
    logic [2:0] idx_s;
    logic valid_s, nb_s, busy_s;

    always #5 clk = ~clk;

    tempo_selector #(.WINDOW_LEN(WL), .ACC_W(24)) u_dut (
        .clk(clk), .reset(reset), .ready(ready),
        .comb60(c0), .comb90(c1), .comb120(c2), .comb180(c3), .comb210(c4), .comb240(c5),
        .tempo_bpm(tempo_bpm), .tempo_idx(tempo_idx), .tempo_valid(tempo_valid),
        .no_beat(no_beat), .busy(busy)
    );

    tempo_selector #(.WINDOW_LEN(16), .ACC_W(10)) u_sat (
        .clk(clk), .reset(reset), .ready(ready_s),
        .comb60(s0), .comb90(8'sd0), .comb120(8'sd0), .comb180(s3), .comb210(8'sd0),
        .comb240(8'sd0),
        .tempo_bpm(bpm_s), .tempo_idx(idx_s), .tempo_valid(valid_s),
        .no_beat(nb_s), .busy(busy_s)
    );

    int checks = 0;
    int errors = 0;

    int     cur [6];
    longint msum [6];
    int     mcnt, cd, pend_idx;
    bit     pend_nb;
    int     exp_bpm, exp_idx;
    bit     exp_nb, exp_valid;
    int     bpm_tab [6] = '{60, 90, 120, 180, 210, 240};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 6; i++) msum[i] = 0;
        mcnt = 0; cd = 0; exp_bpm = 0; exp_idx = 0; exp_nb = 1; exp_valid = 0;
    endtask

    // Window decision: largest energy, first channel that reaches it.
    task automatic decide();
        longint mx = 0;
        for (int i = 0; i < 6; i++) if (msum[i] > mx) mx = msum[i];
        pend_nb = (mx == 0);
        pend_idx = 0;
        for (int i = 5; i >= 0; i--) if (msum[i] == mx) pend_idx = i;
    endtask

    task automatic tick(input bit rdy);
        bit snap = 0;
        ready = rdy;
        c0 = 8'(cur[0]); c1 = 8'(cur[1]); c2 = 8'(cur[2]);
        c3 = 8'(cur[3]); c4 = 8'(cur[4]); c5 = 8'(cur[5]);
        if (rdy) begin
            for (int i = 0; i < 6; i++) begin
                msum[i] += (cur[i] < 0) ? -cur[i] : cur[i];
                if (msum[i] > MAXV) msum[i] = MAXV;
            end
            mcnt++;
            if (mcnt == WL) begin
                decide();
                for (int i = 0; i < 6; i++) msum[i] = 0;
                mcnt = 0;
                snap = 1;
            end
        end
        @(posedge clk); #1;
        exp_valid = 0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                exp_valid = 1;
                exp_nb = pend_nb;
                if (!pend_nb) begin
                    exp_idx = pend_idx;
                    exp_bpm = bpm_tab[pend_idx];
                end
            end
        end
        if (snap) cd = 7;
        chk("valid", 32'(tempo_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(cd > 0));
        chk("bpm", 32'(tempo_bpm), 32'(exp_bpm));
        chk("idx", 32'(tempo_idx), 32'(exp_idx));
        chk("no_beat", 32'(no_beat), 32'(exp_nb));
    endtask

    task automatic send_window(input int gap);
        for (int i = 0; i < WL; i++) begin
            tick(1'b1);
            if (i != WL - 1) repeat (gap) tick(1'b0);
        end
    endtask

    task automatic set_cur(input int a, b, c, d, e, f);
        cur[0] = a; cur[1] = b; cur[2] = c; cur[3] = d; cur[4] = e; cur[5] = f;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bpm"}, 32'(tempo_bpm), 0);
        chk({tag, "_idx"}, 32'(tempo_idx), 0);
        chk({tag, "_valid"}, 32'(tempo_valid), 0);
        chk({tag, "_no_beat"}, 32'(no_beat), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        bit found;
        int mode;
        reset = 1'b1; ready = 1'b0; ready_s = 1'b0; s0 = '0; s3 = '0;
        set_cur(0, 0, 0, 0, 0, 0);
        c0 = '0; c1 = '0; c2 = '0; c3 = '0; c4 = '0; c5 = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        reset = 1'b0;
        repeat (3) tick(1'b0);

        // Scenario 1: single active channel, sparse ready.
        set_cur(0, 0, 10, 0, 0, 0);
        send_window(3);
        repeat (10) tick(1'b0);
        chk("s1_idx", 32'(tempo_idx), 2);
        chk("s1_bpm", 32'(tempo_bpm), 120);
        chk("s1_no_beat", 32'(no_beat), 0);

        // Scenario 2: -128 outweighs +127.
        set_cur(-128, 0, 0, 0, 0, 127);
        send_window(1);
        repeat (10) tick(1'b0);
        chk("s2_idx", 32'(tempo_idx), 0);
        chk("s2_bpm", 32'(tempo_bpm), 60);

        // Scenario 3: tie goes to the lower index; ready every cycle.
        set_cur(0, 5, 0, 0, 5, 0);
        send_window(0);
        repeat (10) tick(1'b0);
        chk("s3_idx", 32'(tempo_idx), 1);
        chk("s3_bpm", 32'(tempo_bpm), 90);

        // Scenario 4: silent window after a 180 BPM decision.
        set_cur(0, 0, 0, 50, 0, 0);
        send_window(2);
        repeat (10) tick(1'b0);
        chk("s4a_bpm", 32'(tempo_bpm), 180);
        set_cur(0, 0, 0, 0, 0, 0);
        send_window(2);
        repeat (10) tick(1'b0);
        chk("s4_no_beat", 32'(no_beat), 1);
        chk("s4_bpm", 32'(tempo_bpm), 180);
        chk("s4_idx", 32'(tempo_idx), 3);

        // Scenario 6: reset during the third compare cycle.
        set_cur(0, 0, 0, 0, 20, 0);
        send_window(1);
        tick(1'b0);
        tick(1'b0);
        reset = 1'b1; ready = 1'b0;
        #1;
        check_reset_vals("s6_async");
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) tick(1'b0);
        check_reset_vals("s6_after");
        set_cur(0, 30, 0, 0, 0, 0);
        send_window(1);
        repeat (10) tick(1'b0);
        chk("s6_idx", 32'(tempo_idx), 1);
        chk("s6_bpm", 32'(tempo_bpm), 90);

        // Random traffic with windows overlapping compare/publish.
        for (int n = 0; n < 480; n++) begin
            mode = (n / 60) % 3;
            for (int i = 0; i < 6; i++) cur[i] = int'($urandom_range(0, 255)) - 128;
            if (mode == 0) tick(1'b1);
            else if (mode == 1) tick($urandom_range(0, 1) == 0);
            else tick($urandom_range(0, 3) == 0);
        end
        repeat (12) tick(1'b0);

        // Scenario 5: 10-bit accumulators saturate instead of wrapping.
        for (int i = 0; i < 16; i++) begin
            s0 = 8'sd64; s3 = 8'sd127; ready_s = 1'b1;
            @(posedge clk); #1;
            ready_s = 1'b0;
            @(posedge clk); #1;
        end
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (valid_s) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("s5_valid_seen", 32'(found), 1);
        chk("s5_snap3", 32'(u_sat.snap[3]), 1023);
        chk("s5_snap0", 32'(u_sat.snap[0]), 1023);
        chk("s5_idx", 32'(idx_s), 0);
        chk("s5_bpm", 32'(bpm_s), 60);
        chk("s5_no_beat", 32'(nb_s), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tempo_selector.md
TEMPO_SELECTOR -- requirements
Module: tempo_selector

Interface
REQ-001 The block SHALL have parameter WINDOW_LEN, default 4096, meaning the number of ready-qualified samples per analysis window; legal range 8..65535.
REQ-002 The block SHALL have parameter ACC_W, default 24, meaning the width of each energy accumulator in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ready, input, 1 bit: one-cycle sample strobe shared with the audio datapath.
REQ-006 The block SHALL have ports comb60, comb90, comb120, comb180, comb210 and comb240, each an input, signed 8 bits, carrying the comb filter outputs for channels 0..5 in that order.
REQ-007 The block SHALL have port tempo_bpm, output, 8 bits: the selected tempo in BPM.
REQ-008 The block SHALL have port tempo_idx, output, 3 bits: the selected channel, 0..5.
REQ-009 The block SHALL have port tempo_valid, output, 1 bit: one-cycle pulse when a new decision is published.
REQ-010 The block SHALL have port no_beat, output, 1 bit: high when the last window had zero energy on every channel.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the FSM is in COMPARE or PUBLISH.

Function
REQ-012 On every clk edge with ready=1, each channel accumulator SHALL add |combN|, an unsigned 8-bit value where |-128| = 128.
REQ-013 Accumulators SHALL saturate at 2^ACC_W-1 and SHALL NOT wrap.
REQ-014 The sample counter SHALL increment on each ready pulse and SHALL reach WINDOW_LEN on the final sample of a window.
REQ-015 On the edge that accepts the final sample, the block SHALL load a snapshot bank with the accumulated values including that sample, clear the accumulators and counter to 0, and enter COMPARE.
REQ-016 Accumulation SHALL continue uninterrupted during COMPARE and PUBLISH, so no sample is dropped.
REQ-017 The FSM SHALL have exactly three states, with these transitions:
- ACCUM -> COMPARE at window end.
- COMPARE lasts 6 cycles and examines one snapshot channel per cycle, in order 0 to 5.
- COMPARE -> PUBLISH.
- PUBLISH -> ACCUM after 1 cycle.
REQ-018 The compare SHALL keep a running maximum and its index, and SHALL replace them only on strictly greater energy, so ties resolve to the lowest index.
REQ-019 In PUBLISH, the block SHALL register tempo_idx and tempo_bpm from the table {60, 90, 120, 180, 210, 240}, and set no_beat = (max energy == 0).
REQ-020 tempo_valid SHALL be high for exactly the cycle following the PUBLISH edge, which is the 7th cycle after the snapshot edge.
REQ-021 When no_beat=1, tempo_bpm and tempo_idx SHALL retain their previous values, and tempo_valid SHALL still pulse.
REQ-022 A ready pulse coincident with a state transition SHALL be accumulated normally into the new window.
REQ-023 Outputs SHALL change only in PUBLISH and on reset.

Reset
REQ-024 Asserting reset at any time, including mid-COMPARE, SHALL immediately force the FSM to ACCUM and clear all accumulators, snapshots and the counter to 0.
REQ-025 Asserting reset SHALL also set tempo_bpm=0, tempo_idx=0, tempo_valid=0, no_beat=1 and busy=0.
REQ-026 A decision interrupted by reset SHALL NOT be published.
REQ-027 The first window after reset release SHALL start with the first ready pulse.

Structure
REQ-028 A shared package SHALL hold NUM_TEMPOS=6, the BPM lookup table, and the state encodings ACCUM, COMPARE and PUBLISH.
REQ-029 One sub-module, energy_acc, SHALL be instantiated six times; it SHALL implement the abs, saturating add, clear and snapshot functions for one channel.
REQ-030 The top level SHALL contain the counter, the FSM and the compare logic.

Verification
REQ-031 Scenario 1: WINDOW_LEN=8, comb120=+10 and all other channels 0, ready every 4 cycles -> tempo_valid pulses 7 cycles after the 8th ready with tempo_idx=2, tempo_bpm=120 and no_beat=0.
REQ-032 Scenario 2: comb60=-128 for all samples and comb240=+127 -> tempo_idx=0 and tempo_bpm=60, because -128 counts as 128.
REQ-033 Scenario 3: tie, with comb90 = comb210 = 5 constant -> tempo_idx=1.
REQ-034 Scenario 4: all inputs 0 for one window after a prior 180 BPM decision -> tempo_valid pulses with no_beat=1, and tempo_bpm stays 180.
REQ-035 Scenario 5: ACC_W=10, comb180=127, WINDOW_LEN=16 -> the snapshot equals 1023 (saturated) and is not wrapped.
REQ-036 Scenario 6: reset asserted on the 3rd COMPARE cycle -> no tempo_valid pulse, all outputs at reset values, and the next window decides correctly.
